or_reduce_pipe: RTL
===================

OR_REDUCE_PIPE -- requirements
Module: or_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of reduction inputs (legal 2..256).
REQ-002 SHALL have parameter CNT_W, default 8, width of the hit counter (legal 2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetl  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_data/mode are valid this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  operand vector to reduce.
REQ-007 SHALL have port mode  input  2  00 OR, 01 AND, 10 XOR (parity), 11 NOR.
REQ-008 SHALL have port acc_clr  input  1  synchronous clear of sticky and count.
REQ-009 SHALL have port out_valid  output  1  q holds a new result this cycle.
REQ-010 SHALL have port q  output  1  reduction result.
REQ-011 SHALL have port sticky  output  1  set if any result with q=1 since last clear.
REQ-012 SHALL have port count  output  CNT_W  number of results with q=1 since last clear, saturating.

Function
REQ-013 SHALL implement a tree of 4-input reduction nodes; LEVELS = ceil(log4(WIDTH)), minimum 1.
REQ-014 SHALL register every tree level, giving fixed latency LEVELS cycles from in_valid to out_valid (WIDTH=16: 2; WIDTH=64: 3; WIDTH=100: 4).
REQ-015 SHALL accept one input per cycle with no backpressure; back-to-back inputs produce back-to-back outputs in order.
REQ-016 SHALL carry mode and a valid bit alongside each level so that each result uses the mode sampled with its own input.
REQ-017 SHALL pad unused node inputs with the identity element of the sampled mode: 0 for OR/XOR/NOR, 1 for AND.
REQ-018 SHALL compute NOR as the inverse of OR, applied only at the final level.
REQ-019 SHALL update q only on cycles where out_valid=1; q holds its last value otherwise.
REQ-020 SHALL, when out_valid=1 and q=1, set sticky and increment count by 1.
REQ-021 SHALL saturate count at 2^CNT_W-1; further hits leave it unchanged and sticky stays 1.
REQ-022 SHALL, on acc_clr=1, clear sticky and count; if out_valid=1 and q=1 in the same cycle, the result belongs to the new epoch (sticky=1, count=1 next cycle).
REQ-023 SHALL ignore in_data and mode when in_valid=0; such cycles produce out_valid=0 LEVELS cycles later.
REQ-024 SHALL have no combinational path from any input to any output.

Reset
REQ-025 SHALL, while resetl=0, force out_valid=0, q=0, sticky=0, count=0 and all pipeline valid bits to 0, independent of clk.
REQ-026 SHALL discard any in-flight results on reset; no out_valid occurs after release until a new in_valid has traversed LEVELS cycles.
REQ-027 SHALL sample in_valid normally on the first rising clk edge after resetl deasserts.

Verification
REQ-028 SHALL be checked by: reset release, in_valid=0 for 10 cycles -> out_valid=0, q=0, sticky=0, count=0 throughout.
REQ-029 SHALL be checked by: WIDTH=16, mode=00, in_data 16'h0000 then 16'h0100 on consecutive cycles -> out_valid 2 and 3 cycles later with q=0 then q=1; afterwards sticky=1, count=1.
REQ-030 SHALL be checked by: WIDTH=16, mode=01 16'hFFFF, mode=10 16'h0007, mode=11 16'h0000, mode=01 16'hFFFE back-to-back -> q sequence 1,1,1,0 on four consecutive out_valid cycles; count=3.
REQ-031 SHALL be checked by: WIDTH=10 instance, mode=01 10'h3FF and mode=10 10'h001 -> q=1 both after 2 cycles (padding correct for AND and XOR).
REQ-032 SHALL be checked by: CNT_W=8, 300 consecutive mode=00 inputs 16'h0001 -> count stops at 255, sticky=1; then acc_clr coincident with a q=1 result -> sticky=1, count=1.
REQ-033 SHALL be checked by: resetl pulsed low for half a cycle while two valid inputs are in flight -> outputs zero immediately, no out_valid on the following 5 cycles with in_valid=0.

Source files
------------

// File: rtl/or_reduce_pipe.sv
// Pipelined OR/AND/XOR/NOR reduction built from registered 4-input nodes.
// Each result also updates a sticky hit flag and a saturating hit counter.
module or_reduce_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic             q,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int calc_levels(input int w);
    int lv;
    int cap;
    lv  = 1;
    cap = 4;
    while (cap < w) begin
      cap = cap * 4;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  // Number of signals present after 'lvl' rounds of 4:1 reduction.
  function automatic int level_width(input int lvl);
    int n;
    n = WIDTH;
    for (int i = 0; i < lvl; i++) n = (n + 3) / 4;
    return n;
  endfunction

  // NOR travels through the tree as OR; it is inverted only at the last level.
  function automatic logic node_reduce(input logic [3:0] x, input logic [1:0] m);
    case (m)
      MODE_AND: return &x;
      MODE_XOR: return ^x;
      default:  return |x;
    endcase
  endfunction

  localparam int LEVELS = calc_levels(WIDTH);

  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_lvl
    localparam int N_IN  = level_width(lvl);
    localparam int N_OUT = level_width(lvl + 1);

    logic [N_IN-1:0]    din;
    logic [1:0]         mode_in;
    logic               valid_in;
    logic [4*N_OUT-1:0] padded;
    logic [N_OUT-1:0]   node_out;
    logic [N_OUT-1:0]   data_r;
    logic               valid_r;

    if (lvl == 0) begin : g_src
      assign din      = in_data;
      assign mode_in  = mode;
      assign valid_in = in_valid;
    end else begin : g_chain
      assign din      = g_lvl[lvl-1].data_r;
      assign mode_in  = g_lvl[lvl-1].g_inner.mode_r;
      assign valid_in = g_lvl[lvl-1].valid_r;
    end

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    always_comb begin
      padded           = {(4*N_OUT){mode_in == MODE_AND}};
      padded[N_IN-1:0] = din;
    end

    for (genvar n = 0; n < N_OUT; n++) begin : g_node
      assign node_out[n] = node_reduce(padded[4*n +: 4], mode_in);
    end

    // NOTE: sequential state uses non-blocking assignment so all stages advance together.
    always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) valid_r <= 1'b0;
      else         valid_r <= valid_in;
    end

    if (lvl == LEVELS - 1) begin : g_last
      always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)       data_r <= '0;
        else if (valid_in) data_r <= (mode_in == MODE_NOR) ? ~node_out : node_out;
      end
    end else begin : g_inner
      logic [1:0] mode_r;

      // NOTE: intermediate data/mode carry no reset; the reset valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (valid_in) begin
          data_r <= node_out;
          mode_r <= mode_in;
        end
      end
    end
  end

  assign out_valid = g_lvl[LEVELS-1].valid_r;
  assign q         = g_lvl[LEVELS-1].data_r[0];

  logic hit;
  assign hit = out_valid & q;

  // A hit coincident with a clear opens the new epoch rather than being lost.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (acc_clr) begin
      sticky <= hit;
      count  <= hit ? CNT_ONE : '0;
    end else if (hit) begin
      sticky <= 1'b1;
      if (count != CNT_MAX) count <= count + CNT_ONE;
    end
  end

endmodule
